program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 139 +++++++++++++
 tb/tb_program_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Streams WORD_COUNT instruction words from a valid/ready source into an
//   instruction memory. Program control stays suspended for the whole load
//   and is released when the last word has been written.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, one extra word follows the program. It is compared with
//     the 32-bit running sum of the loaded words, and any difference raises
//     error. When undefined, there is no sum register and error is tied low.
//
// Ports
//   clk              in   sole clock, rising edge
//   reset            in   synchronous, active-high
//   start            in   one-cycle load request (honoured in IDLE and DONE)
//   inValid/inData   in   source handshake and 32-bit word
//   inReady          out  high while loading, decoded from state
//   writeEnable      out  memory write strobe, one cycle per accepted word
//   writeAddress     out  7-bit memory word address
//   writeInstruction out  32-bit memory write data
//   suspendEnable    out  holds program control suspended while high
//   done             out  load complete
//   error            out  checksum mismatch (checksum build only)
module program_loader #(
  parameter int WORD_COUNT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        inValid,
  input  logic [31:0] inData,
  output logic        inReady,
  output logic        writeEnable,
  output logic [6:0]  writeAddress,
  output logic [31:0] writeInstruction,
  output logic        suspendEnable,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  word_idx;
  logic        xfer;
  logic        last_word;
  logic        restart;

  assign xfer      = inValid && (state == LOAD);
  assign last_word = (word_idx == 7'(WORD_COUNT - 1));
  // A new load can only begin from IDLE or DONE; start elsewhere is ignored.
  assign restart   = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    inReady       = 1'b0;
    suspendEnable = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        inReady = 1'b1;
        if (inValid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // The checksum word is taken on inValid alone; inReady stays low
      // because this word is never written to memory.
      CHECK: begin
        if (inValid) state_nxt = DONE;
      end
`endif
      DONE: begin
        suspendEnable = 1'b0;
        done          = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- write stage: accepted word registered toward memory (1-cycle latency)
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx         <= 7'd0;
      writeEnable      <= 1'b0;
      writeAddress     <= 7'd0;
      writeInstruction <= 32'd0;
    end else begin
      writeEnable <= xfer;
      if (xfer) begin
        writeAddress     <= word_idx;
        writeInstruction <= inData;
        word_idx         <= word_idx + 7'd1;
      end
      if (restart) begin
        word_idx <= 7'd0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum   <= 32'd0;
      error <= 1'b0;
    end else begin
      if (restart) begin
        sum   <= 32'd0;
        error <= 1'b0;
      end else if (xfer) begin
        sum <= sum + inData;
      end
      if ((state == CHECK) && inValid) begin
        error <= (inData != sum);
      end
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int WC = 128;

  logic        clk = 1'b0;
  logic        reset, start, inValid;
  logic [31:0] inData;
  logic        inReady, writeEnable, suspendEnable, done, error;
  logic [6:0]  writeAddress;
  logic [31:0] writeInstruction;

  always #5 clk = ~clk;

  program_loader #(.WORD_COUNT(WC)) dut (
    .clk(clk), .reset(reset), .start(start), .inValid(inValid), .inData(inData),
    .inReady(inReady), .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeInstruction(writeInstruction), .suspendEnable(suspendEnable),
    .done(done), .error(error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the loader should be doing, in terms of the
  // load in progress (words accepted so far) rather than the FSM.
  bit          m_load, m_chk, m_done, m_err;
  int          m_idx;
  bit          m_we;
  logic [6:0]  m_addr;
  logic [31:0] m_data, m_sum;

  task automatic model_reset();
    m_load = 0; m_chk = 0; m_done = 0; m_err = 0;
    m_idx = 0; m_we = 0; m_addr = '0; m_data = '0; m_sum = '0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input bit r, input bit s, input bit v, input logic [31:0] d);
    reset = r; start = s; inValid = v; inData = d;
    @(posedge clk);
    m_we = 0;
    if (r) begin
      model_reset();
    end else if (m_load) begin
      if (v) begin
        m_we   = 1;
        m_addr = m_idx[6:0];
        m_data = d;
        m_sum  = m_sum + d;
        m_idx++;
        if (m_idx == WC) begin
          m_load = 0;
`ifdef LOADER_CHECKSUM_EN
          m_chk = 1;
`else
          m_done = 1;
`endif
        end
      end
    end else if (m_chk) begin
      if (v) begin
        m_err  = (d != m_sum);
        m_chk  = 0;
        m_done = 1;
      end
    end else if (s) begin
      m_load = 1; m_done = 0; m_err = 0; m_idx = 0; m_sum = '0;
    end
    #1;
    chk("inReady", 32'(inReady), 32'(m_load));
    chk("writeEnable", 32'(writeEnable), 32'(m_we));
    chk("writeAddress", 32'(writeAddress), 32'(m_addr));
    chk("writeInstruction", writeInstruction, m_data);
    chk("suspendEnable", 32'(suspendEnable), 32'(!m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
  endtask

  // Drive random stalls (and ignored start pulses) until the model says done.
  task automatic finish_load(input int stall_pct, input bit bad_sum);
    int n;
    logic [31:0] d;
    n = 0;
    while (!m_done && n < 3000) begin
      d = $urandom;
      if (m_chk) d = bad_sum ? m_sum + 32'd1 : m_sum;
      step(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) >= stall_pct), d);
      n++;
    end
    chk("load_timeout", 32'(m_done), 32'd1);
  endtask

  int run;
  logic [31:0] check_word;

  initial begin
    reset = 1; start = 0; inValid = 0; inData = '0;
    model_reset();

    // Reset state, including a start and valid word overridden by reset.
    step(1, 1, 1, 32'hdeadbeef);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h12345678);   // idle: valid without start is not taken

    // Back-to-back load of 0x7f downto 0x00.
    step(0, 1, 0, 0);
    run = 0;
    for (int i = 0; i < WC; i++) begin
      step(0, 0, 1, 32'(WC - 1 - i));
      if (writeEnable) run++;
    end
    chk("we_run", 32'(run), 32'(WC));
`ifdef LOADER_CHECKSUM_EN
    check_word = m_sum;
    step(0, 0, 1, check_word);
    chk("sum_ok_err", 32'(error), 32'd0);
`endif
    step(0, 0, 0, 0);
    chk("done_after_load", 32'(done), 32'd1);

    // From DONE: restart, start pulse at index 5 is ignored.
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom);
    step(0, 1, 1, 32'hcafe0005);
    chk("no_restart_addr", 32'(writeAddress), 32'd5);
    step(0, 0, 1, 32'hcafe0006);
    chk("continue_addr", 32'(writeAddress), 32'd6);
    finish_load(0, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("sum_bad_err", 32'(error), 32'd1);
`endif

    // Reset after the 10th transfer, then reload from address 0.
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, $urandom);
    step(1, 1, 1, 32'h0badf00d);
    step(0, 0, 0, 0);
    chk("post_reset_we", 32'(writeEnable), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h00c0ffee);
    chk("reload_addr0", 32'(writeAddress), 32'd0);
    finish_load(50, 0);

    // Randomly stalled loads, alternating checksum outcome.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      finish_load(30 + 20 * k, k[0]);
      for (int i = 0; i < 3; i++) step(0, 0, $urandom_range(0, 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
